// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width, register-address width/type and
// the hard-wired zero register index. Imported by every pipeline stage.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage buffer to writeback-stage bundle.
//   i_mem_buf_inst_valid : buffer holds a real instruction (not a bubble)
//   i_mem_buf_rd_number  : destination register
//   i_mem_buf_result     : final result (ALU or load data)
//   i_mem_buf_we         : instruction writes rd (low for stores/branches)
// master = memory stage (drives), slave = writeback stage (receives).
interface wb_stage_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    logic            i_mem_buf_inst_valid;
    reg_addr_t       i_mem_buf_rd_number;
    logic [XLEN-1:0] i_mem_buf_result;
    logic            i_mem_buf_we;

    modport master (
        output i_mem_buf_inst_valid,
        output i_mem_buf_rd_number,
        output i_mem_buf_result,
        output i_mem_buf_we
    );

    modport slave (
        input i_mem_buf_inst_valid,
        input i_mem_buf_rd_number,
        input i_mem_buf_result,
        input i_mem_buf_we
    );

endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: one synchronous write port, two asynchronous
// read ports. Address 0 always reads zero; a read hitting the address being
// written this cycle returns the write data (write-through bypass).
//   clk, reset_n   : clock, async active-low reset (clears all entries)
//   we/wr_addr/wr_data       : write port, committed at posedge
//   rd_addr_a/rd_data_a      : read port A
//   rd_addr_b/rd_data_b      : read port B
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = riscv_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  reg_addr_t       wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  reg_addr_t       rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  reg_addr_t       rd_addr_b,
    output logic [XLEN-1:0] rd_data_b
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is reset and never written; reads of it are masked below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (we && (wr_addr != X0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == X0) begin
            rd_data_a = '0;
        end else if (we && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == X0) begin
            rd_data_b = '0;
        end else if (we && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: captures the retiring instruction from the memory buffer
// every cycle (never stalls), commits it to the register file on the next
// edge, exposes it as a forwarding source and counts retired instructions.
//   clk, reset_n            : clock, async active-low reset
//   mem_buf                 : memory-stage buffer (wb_stage_if.slave)
//   i_rs1_number/o_a_val    : read port A
//   i_rs2_number/o_b_val    : read port B
//   o_wb_rd_number/o_wb_result/o_wb_valid : forwarding source
//   o_retired               : retired-instruction count (wraps silently)
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = riscv_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset_n,
    wb_stage_if.slave       mem_buf,
    input  reg_addr_t       i_rs1_number,
    input  reg_addr_t       i_rs2_number,
    output logic [XLEN-1:0] o_a_val,
    output logic [XLEN-1:0] o_b_val,
    output reg_addr_t       o_wb_rd_number,
    output logic [XLEN-1:0] o_wb_result,
    output logic            o_wb_valid,
    output logic [31:0]     o_retired
);

    logic            wb_we_q;
    logic            wb_inst_valid_q;
    reg_addr_t       wb_rd;
    logic [XLEN-1:0] wb_result;
    logic [31:0]     retired_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_we_q         <= 1'b0;
            wb_inst_valid_q <= 1'b0;
            wb_rd           <= '0;
            wb_result       <= '0;
            retired_q       <= '0;
        end else begin
            wb_inst_valid_q <= mem_buf.i_mem_buf_inst_valid;
            // Writes to x0 are dropped here so they neither commit nor forward.
            wb_we_q         <= mem_buf.i_mem_buf_inst_valid & mem_buf.i_mem_buf_we
                               & (mem_buf.i_mem_buf_rd_number != X0);
            wb_rd           <= mem_buf.i_mem_buf_rd_number;
            wb_result       <= mem_buf.i_mem_buf_result;
            // Every real instruction retires, including stores and rd=x0.
            if (wb_inst_valid_q) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (wb_we_q),
        .wr_addr   (wb_rd),
        .wr_data   (wb_result),
        .rd_addr_a (i_rs1_number),
        .rd_data_a (o_a_val),
        .rd_addr_b (i_rs2_number),
        .rd_data_b (o_b_val)
    );

    assign o_wb_valid     = wb_we_q;
    assign o_wb_rd_number = wb_rd;
    assign o_wb_result    = wb_result;
    assign o_retired      = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        reset_n;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic [31:0] a_val;
    logic [31:0] b_val;
    reg_addr_t   wb_rd_number;
    logic [31:0] wb_result;
    logic        wb_valid;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    wb_stage_if #(.XLEN(32)) mem_buf ();

    wb_stage #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_buf        (mem_buf.slave),
        .i_rs1_number   (rs1),
        .i_rs2_number   (rs2),
        .o_a_val        (a_val),
        .o_b_val        (b_val),
        .o_wb_rd_number (wb_rd_number),
        .o_wb_result    (wb_result),
        .o_wb_valid     (wb_valid),
        .o_retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic present(input logic v, input logic [4:0] rd, input logic [31:0] res, input logic we);
        mem_buf.i_mem_buf_inst_valid = v;
        mem_buf.i_mem_buf_rd_number  = rd;
        mem_buf.i_mem_buf_result     = res;
        mem_buf.i_mem_buf_we         = we;
    endtask

    task automatic bubble();
        present(1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        rs1 = '0;
        rs2 = '0;
        bubble();
        #12;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd_number}, 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // All registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(32 - i);
            #1;
            check($sformatf("rst_a_x%0d", i), a_val, 32'd0);
            check($sformatf("rst_b_x%0d", 32 - i), b_val, 32'd0);
        end
        check("rst_retired2", retired, 32'd0);
        check("rst_wb_valid2", {31'd0, wb_valid}, 32'd0);

        // Single write rd=5
        present(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        tick();
        bubble();
        rs1 = 5'd5;
        #1;
        check("w5_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("w5_wb_rd", {27'd0, wb_rd_number}, 32'd5);
        check("w5_wb_result", wb_result, 32'hDEAD_BEEF);
        check("w5_bypass", a_val, 32'hDEAD_BEEF);
        check("w5_retired_n1", retired, 32'd0);
        tick();
        check("w5_array", a_val, 32'hDEAD_BEEF);
        check("w5_wb_valid_n2", {31'd0, wb_valid}, 32'd0);
        check("w5_retired_n2", retired, 32'd1);

        // Write to x0
        present(1'b1, 5'd0, 32'h0000_1234, 1'b1);
        tick();
        bubble();
        rs1 = 5'd0;
        #1;
        check("x0_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("x0_wb_result", wb_result, 32'h0000_1234);
        check("x0_read", a_val, 32'd0);
        tick();
        check("x0_read2", a_val, 32'd0);
        check("x0_retired", retired, 32'd2);

        // Back-to-back writes to x7
        present(1'b1, 5'd7, 32'h11, 1'b1);
        tick();
        present(1'b1, 5'd7, 32'h22, 1'b1);
        rs2 = 5'd7;
        #1;
        check("b2b_n1", b_val, 32'h11);
        tick();
        bubble();
        #1;
        check("b2b_n2", b_val, 32'h22);
        check("b2b_retired_n2", retired, 32'd3);
        tick();
        check("b2b_n3", b_val, 32'h22);
        check("b2b_retired_n3", retired, 32'd4);

        // Bubble: no count, no write
        rs1 = 5'd9;
        present(1'b0, 5'd9, 32'h55, 1'b1);
        tick();
        bubble();
        #1;
        check("bub_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("bub_retired", retired, 32'd4);
        check("bub_x9", a_val, 32'd0);

        // Store: counts, x9 unchanged
        present(1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        bubble();
        #1;
        check("st_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("st_x9_n1", a_val, 32'd0);
        tick();
        check("st_retired", retired, 32'd5);
        check("st_x9", a_val, 32'd0);

        // Mid-operation reset while a write to x3 is pending
        present(1'b1, 5'd3, 32'h0000_CAFE, 1'b1);
        tick();
        bubble();
        rs1 = 5'd3;
        rs2 = 5'd5;
        #1;
        check("mr_bypass", a_val, 32'h0000_CAFE);
        reset_n = 1'b0;
        #1;
        check("mr_x3", a_val, 32'd0);
        check("mr_x5", b_val, 32'd0);
        check("mr_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mr_retired", retired, 32'd0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        check("mr_x3_after", a_val, 32'd0);
        check("mr_x5_after", b_val, 32'd0);
        check("mr_retired_after", retired, 32'd0);

        // Counter wrap
        present(1'b1, 5'd0, 32'h0, 1'b0);
        tick();
        bubble();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_pre", retired, 32'hFFFF_FFFF);
        tick();
        check("wrap", retired, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
